// File: rtl/ring_link_stage.sv
// Elastic FIFO stage on a ring link: buffers valid packets, forwards them in order,
// drives registered backpressure upstream and keeps forwarded/dropped statistics.
module ring_link_stage #(
    parameter int unsigned PACKET_SIZE = 49,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned BP_MARGIN   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PACKET_SIZE-1:0]   link_in,
    input  logic                     backpressure_rd,
    output logic [PACKET_SIZE-1:0]   link_out,
    output logic                     backpressure_wr,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [63:0]              total_forwarded,
    output logic [15:0]              total_dropped
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    // (DEPTH - count_next) < BP_MARGIN rearranged to avoid unsigned underflow
    localparam logic [CW-1:0] BP_LIMIT   = CW'(DEPTH - BP_MARGIN);

    logic [PACKET_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic                   push;
    logic                   pop;
    logic                   accept;
    logic                   drop;

    always_comb begin
        push       = link_in[PACKET_SIZE-1];
        pop        = (count != '0) && !backpressure_rd;
        accept     = push && ((count != FULL_COUNT) || pop);
        drop       = push && !accept;
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= link_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            link_out        <= '0;
            backpressure_wr <= 1'b0;
            total_forwarded <= '0;
            total_dropped   <= '0;
        end else begin
            count           <= count_next;
            backpressure_wr <= (count_next > BP_LIMIT);
            if (pop) begin
                link_out        <= mem[rd_ptr];
                rd_ptr          <= rd_ptr + PW'(1);
                total_forwarded <= total_forwarded + 64'd1;
            end else begin
                link_out <= '0;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (drop && (total_dropped != '1)) begin
                total_dropped <= total_dropped + 16'd1;
            end
        end
    end

    assign occupancy = count;

endmodule

// File: tb/tb_ring_link_stage.sv
// Randomized self-checking bench for ring_link_stage against a queue-based reference model.
module tb_ring_link_stage;

    localparam int unsigned PS    = 49;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BPM   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [PS-1:0]   link_in;
    logic            bp_rd;
    logic [PS-1:0]   link_out;
    logic            bp_wr;
    logic [2:0]      occ;
    logic [63:0]     fwd;
    logic [15:0]     drp;

    ring_link_stage #(
        .PACKET_SIZE (PS),
        .DEPTH       (DEPTH),
        .BP_MARGIN   (BPM)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .link_in         (link_in),
        .backpressure_rd (bp_rd),
        .link_out        (link_out),
        .backpressure_wr (bp_wr),
        .occupancy       (occ),
        .total_forwarded (fwd),
        .total_dropped   (drp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [PS-1:0]   mq[$];
    longint unsigned m_fwd;
    int unsigned     m_drp;
    logic [PS-1:0]   m_out;
    logic            m_bp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fwd = 0;
        m_drp = 0;
        m_out = '0;
        m_bp  = 1'b0;
    endtask

    task automatic check_all(input string ph);
        check_eq({ph, ".link_out"}, 64'(link_out), 64'(m_out));
        check_eq({ph, ".occupancy"}, 64'(occ), 64'(mq.size()));
        check_eq({ph, ".bp_wr"}, 64'(bp_wr), 64'(m_bp));
        check_eq({ph, ".forwarded"}, fwd, m_fwd);
        check_eq({ph, ".dropped"}, 64'(drp), 64'(m_drp));
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic step(input logic [PS-1:0] pkt, input logic stall, input string ph);
        int unsigned n;
        logic        popm;
        link_in = pkt;
        bp_rd   = stall;
        n       = mq.size();
        popm    = (n != 0) && !stall;
        m_out   = '0;
        if (popm) begin
            m_out = mq.pop_front();
            m_fwd++;
        end
        if (pkt[PS-1]) begin
            if (n < DEPTH || popm) mq.push_back(pkt);
            else if (m_drp < 65535) m_drp++;
        end
        m_bp = (int'(DEPTH) - mq.size()) < int'(BPM);
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    function automatic logic [PS-1:0] rand_pkt();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return {1'b1, r[47:0]};
    endfunction

    localparam logic [PS-1:0] T2PKT = {1'b1, 16'h0010, 16'd1, 16'd3};

    logic [PS-1:0]   t3p [4];
    longint unsigned fwd_base;
    int unsigned     drp_base;

    initial begin
        rst_n   = 1'b0;
        link_in = '0;
        bp_rd   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // T1: reset in the middle of traffic
        for (int i = 0; i < 3; i++) step(rand_pkt(), 1'b1, "t1_fill");
        for (int i = 0; i < 2; i++) step(rand_pkt(), 1'b0, "t1_run");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t1_async");
        @(posedge clk);
        #1;
        check_all("t1_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // T2: two-cycle latency, no bypass
        step(T2PKT, 1'b0, "t2_in");
        check_eq("t2_no_bypass", 64'(link_out), 64'd0);
        step('0, 1'b0, "t2_out");
        check_eq("t2_pkt", 64'(link_out), 64'(T2PKT));
        check_eq("t2_fwd", fwd, 64'd1);
        step('0, 1'b0, "t2_idle");
        check_eq("t2_single", 64'(link_out), 64'd0);

        // T3: stalled fill then overflow
        for (int i = 0; i < 4; i++) begin
            t3p[i] = rand_pkt();
            step(t3p[i], 1'b1, "t3_fill");
            if (i == 1) check_eq("t3_bp_after2", 64'(bp_wr), 64'd0);
            if (i == 2) check_eq("t3_bp_after3", 64'(bp_wr), 64'd1);
            check_eq("t3_link_zero", 64'(link_out), 64'd0);
        end
        check_eq("t3_occ_full", 64'(occ), 64'd4);
        step(rand_pkt(), 1'b1, "t3_over");
        check_eq("t3_dropped", 64'(drp), 64'd1);
        check_eq("t3_occ_after_drop", 64'(occ), 64'd4);

        // T4: drain in order
        for (int i = 0; i < 4; i++) begin
            step('0, 1'b0, "t4_drain");
            check_eq("t4_order", 64'(link_out), 64'(t3p[i]));
            check_eq("t4_bp", 64'(bp_wr), (i >= 1) ? 64'd0 : 64'd1);
        end
        check_eq("t4_occ_empty", 64'(occ), 64'd0);

        // T5: full FIFO with simultaneous push/pop, pointers wrap
        drp_base = m_drp;
        for (int i = 0; i < 4; i++) step(rand_pkt(), 1'b1, "t5_fill");
        for (int i = 0; i < 10; i++) begin
            step(rand_pkt(), 1'b0, "t5_pp");
            check_eq("t5_occ", 64'(occ), 64'd4);
        end
        check_eq("t5_nodrop", 64'(drp), 64'(drp_base));
        for (int i = 0; i < 4; i++) step('0, 1'b0, "t5_drain");

        // T6: 100 packets, downstream stalls 3 cycles of every 6, upstream honours bp
        begin
            int unsigned sent;
            int unsigned next_seq;
            int unsigned cyc;
            logic [PS-1:0] p;
            logic [63:0] r;
            sent     = 0;
            next_seq = 0;
            cyc      = 0;
            fwd_base = m_fwd;
            drp_base = m_drp;
            while ((sent < 100 || mq.size() != 0) && cyc < 2000) begin
                r = {$urandom(), $urandom()};
                if (sent < 100 && !m_bp) begin
                    p = {1'b1, 16'(sent), r[31:0]};
                    sent++;
                end else begin
                    p = {1'b0, r[47:0]};
                end
                step(p, 1'(((cyc / 3) % 2) == 1), "t6");
                if (link_out[PS-1]) begin
                    check_eq("t6_seq", 64'(link_out[47:32]), 64'(next_seq));
                    next_seq++;
                end
                cyc++;
            end
            if (cyc >= 2000) check_eq("t6_timeout", 64'(cyc), 64'(0));
            check_eq("t6_fwd", fwd - fwd_base, 64'd100);
            check_eq("t6_drop", 64'(drp), 64'(drp_base));
            check_eq("t6_count", 64'(next_seq), 64'd100);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
